// File: rtl/alu_issue_stage.sv
// ALU issue slice: decodes ALUOp/Funct, selects and extends operand B, and
// buffers issued ops in a 2-entry skid buffer. Optional: ALU_ISSUE_ILLEGAL_DETECT_EN.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        ALUOp,
   input  logic [5:0]        Funct,
   input  logic              ALUSrc,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [15:0]       Imm16,
   input  logic [REG_W-1:0]  WriteRegIn,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2,
   output logic [3:0]        ALUCtl,
   output logic [REG_W-1:0]  WriteRegOut
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
  ,output logic              IllegalOp
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      logic [3:0]        ctl;
      logic [REG_W-1:0]  wr;
   } entry_t;

   function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
      logic [3:0] ctl;
      ctl = 4'b1111;
      case (op)
         2'b00:   ctl = 4'b0010;
         2'b01:   ctl = 4'b0110;
         2'b11:   ctl = 4'b0001;
         2'b10: begin
            case (fn)
               6'b100000: ctl = 4'b0010;
               6'b100010: ctl = 4'b0110;
               6'b100100: ctl = 4'b0000;
               6'b100101: ctl = 4'b0001;
               6'b101010: ctl = 4'b0111;
               default:   ctl = 4'b1111;
            endcase
         end
         default: ctl = 4'b1111;
      endcase
      return ctl;
   endfunction

   entry_t     head_r;
   entry_t     tail_r;
   logic [1:0] count_r;
   entry_t     new_s;
   logic       acc_s;
   logic       cons_s;

   // Input-side decode and operand-B selection; immediate-logic ops zero-extend.
   always_comb begin
      new_s     = '0;
      new_s.d1  = ReadData1;
      new_s.ctl = alu_decode(ALUOp, Funct);
      new_s.wr  = WriteRegIn;
      if (!ALUSrc) begin
         new_s.d2 = ReadData2;
      end else if (ALUOp == 2'b11) begin
         new_s.d2 = {{(DATA_W-16){1'b0}}, Imm16};
      end else begin
         new_s.d2 = {{(DATA_W-16){Imm16[15]}}, Imm16};
      end
   end

   assign InReady     = (count_r != 2'd2);
   assign OutValid    = (count_r != 2'd0);
   assign acc_s       = InValid && InReady;
   assign cons_s      = OutValid && OutReady;
   assign Data1       = head_r.d1;
   assign Data2       = head_r.d2;
   assign ALUCtl      = head_r.ctl;
   assign WriteRegOut = head_r.wr;

   // Skid buffer state: head is always the oldest op; flush keeps last head values visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 2'd0;
         head_r  <= '0;
         tail_r  <= '0;
      end else if (Flush) begin
         count_r <= 2'd0;
      end else begin
         case (count_r)
            2'd0: begin
               if (acc_s) begin
                  head_r  <= new_s;
                  count_r <= 2'd1;
               end
            end
            2'd1: begin
               if (acc_s && cons_s) begin
                  head_r <= new_s;
               end else if (acc_s) begin
                  tail_r  <= new_s;
                  count_r <= 2'd2;
               end else if (cons_s) begin
                  count_r <= 2'd0;
               end
            end
            2'd2: begin
               if (cons_s) begin
                  head_r  <= tail_r;
                  count_r <= 2'd1;
               end
            end
            default: count_r <= 2'd0;
         endcase
      end
   end

`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
   logic illegal_r;
   assign IllegalOp = illegal_r;

   // Sticky flag for any op that reaches the buffer decoding to PASS; survives Flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_r <= 1'b0;
      end else if (acc_s && !Flush && (new_s.ctl == 4'b1111)) begin
         illegal_r <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX-side issue slice that produces the operand pair and 4-bit ALU control code consumed by the EX-stage ALU.
- Decodes ALUOp/Funct into the ALU control encoding.
- Selects and extends the second operand.
- Buffers issued operations in a 2-entry skid buffer with valid/ready handshakes on both sides, so ALU-side backpressure never drops an instruction.
- Sits between the register-file read / decode logic and the ALU.

Parameters:
DATA_W, 32, operand width (Data1/Data2/ReadData*)
REG_W, 5, destination register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
Flush  input  1  synchronous squash of all buffered and incoming ops
InValid  input  1  upstream op valid
InReady  output  1  slice can accept an op this cycle
ALUOp  input  2  00 add, 01 sub, 10 R-type (use Funct), 11 immediate-logic
Funct  input  6  R-type function field
ALUSrc  input  1  1: Data2 from immediate, 0: from ReadData2
ReadData1  input  DATA_W  register-file operand A
ReadData2  input  DATA_W  register-file operand B
Imm16  input  16  instruction immediate
WriteRegIn  input  REG_W  destination register index
OutValid  output  1  head entry valid toward ALU
OutReady  input  1  ALU/EX consumes head entry this cycle
Data1  output  DATA_W  ALU operand A (head entry)
Data2  output  DATA_W  ALU operand B (head entry)
ALUCtl  output  4  ALU control code (head entry)
WriteRegOut  output  REG_W  destination index (head entry)

Behaviour:
- Control encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, PASS 1111 (ALU passes Data1 unchanged).
- Decode:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0110.
  - ALUOp 11 -> 0001.
  - ALUOp 10 by Funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, any other->1111.
- Operand B:
  - ALUSrc=0 -> ReadData2.
  - ALUSrc=1, ALUOp=11 -> zero-extended Imm16.
  - ALUSrc=1, any other ALUOp -> sign-extended Imm16.
  - Extension is to DATA_W bits.
- Data1 = ReadData1, captured unchanged.
- Decode and extension are combinational on the input side. Decoded values are registered into the buffer; no output is driven combinationally from inputs.
- Buffer:
  - 2 entries (head, tail) with count 0..2.
  - Accept when InValid && InReady.
  - Consume when OutValid && OutReady.
- InReady = (count < 2); registered state only, no combinational path from OutReady.
- Latency: an op accepted in cycle N appears at the outputs with OutValid=1 in cycle N+1 when the buffer was empty.
- Simultaneous accept and consume:
  - count unchanged.
  - New op enters tail position (or head if count was 1 and head leaves).
  - Order preserved (FIFO).
- count=2 (full): InReady=0; InValid ignored.
- count=0 (empty): OutValid=0; Data1/Data2/ALUCtl/WriteRegOut hold their last values. Verification must not check them while OutValid=0.
- Outputs remain stable while OutValid=1 and OutReady=0.
- Flush=1:
  - Next cycle count=0, OutValid=0, InReady=1.
  - An op presented in the Flush cycle is dropped.
  - Flush has priority over accept and consume.
- Reset=1:
  - Next cycle count=0, OutValid=0, InReady=1.
  - Data1=0, Data2=0, ALUCtl=0000, WriteRegOut=0.
  - Reset has priority over Flush. Reset mid-operation discards all entries.

Optional Feature:
Macro ALU_ISSUE_ILLEGAL_DETECT_EN.
- Defined:
  - Adds output IllegalOp (1 bit), a sticky flag.
  - IllegalOp sets to 1 the cycle after an accepted op decodes to 1111.
  - IllegalOp clears only on reset (not on Flush).
  - The offending op is still buffered and issued as PASS.
- Undefined: no IllegalOp port; unsupported Funct silently decodes to PASS 1111.

Test Plan:
1. Decode sweep: ALUOp=10 with Funct 100000/100010/100100/100101/101010/000000 each accepted, OutReady=1 -> ALUCtl 0010/0110/0000/0001/0111/1111 one cycle after each accept, in order.
2. Immediate extension: ALUSrc=1, Imm16=16'hFFF0 with ALUOp=00 -> Data2=32'hFFFFFFF0; same Imm16 with ALUOp=11 -> Data2=32'h0000FFF0; ReadData1=32'h12345678 -> Data1=32'h12345678.
3. Backpressure: OutReady=0, three back-to-back InValid ops (WriteRegIn 1,2,3) -> ops 1,2 accepted, InReady=0 on the third cycle, op 3 held upstream; raise OutReady -> WriteRegOut sequence 1,2,3 with no loss or duplication.
4. Flush: buffer full (count=2), assert Flush together with InValid=1 -> next cycle OutValid=0, InReady=1; the flushed-cycle op never appears at the outputs.
5. Reset mid-stream: count=1, assert reset -> next cycle OutValid=0, ALUCtl=0000, Data1=Data2=0, WriteRegOut=0; with macro defined and IllegalOp previously 1 -> IllegalOp=0.
6. Simultaneous accept/consume at count=1 for 8 cycles with OutReady=1 -> OutValid stays 1, count stays 1, ops emerge exactly one cycle after acceptance.
